oam_dma_master: RTL and testbench

- Bus initiator for the memory interface served by the memory responder model. Drives wen/ren/addr/data and waits on rdy.
- Implements NES OAM DMA: on a start pulse, copies 256 bytes from CPU page {page,8'h00}..{page,8'hFF} to the OAM data port (default 16'h2004), one read followed by one write per byte.
- Sits beside the CPU core. Its busy output stalls the CPU while it owns the bus.

---
 rtl/mem_pkg.sv | 7 +
 rtl/oam_dma_master.sv | 85 ++++++++
 tb/tb_oam_dma_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: bus types, OAM port address and DMA state encoding shared with the memory responder
package mem_pkg;
  typedef logic [15:0] t_addr;
  typedef logic [7:0] t_data;
  localparam t_addr OAM_DATA_ADDR = 16'h2004;
  typedef enum logic [2:0] {IDLE, ALIGN, RD, WR, DONE} t_dma_state;
endpackage

// File: rtl/oam_dma_master.sv
// oam_dma_master: NES OAM DMA bus initiator copying one page to the OAM data port, read then write per byte
module oam_dma_master #(
  parameter mem_pkg::t_addr OAM_DATA_ADDR = mem_pkg::OAM_DATA_ADDR,
  parameter int ALIGN_CYCLES = 1,
  parameter int NUM_BYTES = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     page,
  output logic           busy,
  output logic           done,
  output logic           wen,
  output logic           ren,
  input  logic           rdy,
  output mem_pkg::t_addr addr_out,
  output mem_pkg::t_data data_out,
  input  mem_pkg::t_data data_in
);
  import mem_pkg::*;
  t_dma_state state, state_n;
  logic [7:0] page_q, page_n, idx, idx_n;
  logic [1:0] cnt, cnt_n;
  t_data byte_q, byte_n;
  always_comb begin
    state_n = state;
    page_n = page_q;
    idx_n = idx;
    cnt_n = cnt;
    byte_n = byte_q;
    case (state)
      IDLE: if (start) begin
        page_n = page;
        idx_n = '0;
        cnt_n = '0;
        state_n = (ALIGN_CYCLES > 0) ? ALIGN : RD;
      end
      ALIGN: begin
        cnt_n = cnt + 2'd1;
        if (cnt == 2'(ALIGN_CYCLES - 1)) state_n = RD;
      end
      RD: if (rdy) begin
        byte_n = data_in;
        state_n = WR;
      end
      WR: if (rdy) begin
        if (idx == 8'(NUM_BYTES - 1)) state_n = DONE;
        else begin
          idx_n = idx + 8'd1;
          state_n = RD;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they change together with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      page_q <= '0;
      idx <= '0;
      cnt <= '0;
      byte_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      wen <= 1'b0;
      ren <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
    end else begin
      state <= state_n;
      page_q <= page_n;
      idx <= idx_n;
      cnt <= cnt_n;
      byte_q <= byte_n;
      busy <= state_n inside {ALIGN, RD, WR};
      done <= state_n == DONE;
      ren <= state_n == RD;
      wen <= state_n == WR;
      addr_out <= (state_n == RD) ? {page_n, idx_n} : (state_n == WR) ? OAM_DATA_ADDR : '0;
      data_out <= (state_n == WR) ? byte_n : data_out;
    end
  end
endmodule

// File: tb/tb_oam_dma_master.sv
// tb_oam_dma_master: directed checks of the OAM DMA master against an inline memory responder
module tb_oam_dma_master;
  logic clk = 0, rst = 1;
  logic start0 = 0, start1 = 0;
  logic [7:0] page0 = 0, page1 = 0;
  logic busy0, done0, wen0, ren0, busy1, done1, wen1, ren1;
  logic rdy0 = 1, rdy1 = 1;
  logic [15:0] addr0, addr1;
  logic [7:0] data0, data1, din0, din1;
  logic [7:0] mem [0:65535];
  int total = 0, bad = 0;
  int rdy_mode = 0, cyc = 0;
  int busy_cnt0 = 0, done_cnt0 = 0, both_cnt = 0, stab_cnt = 0;
  int busy_cnt1 = 0, done_cnt1 = 0;
  logic [15:0] wq_a[$], rq0[$], rq1[$];
  logic [7:0] wq_d[$];
  logic p_req = 0, p_rdy = 0, p_rst = 1, p_ren = 0, p_wen = 0;
  logic [15:0] p_addr = 0;
  logic [7:0] p_data = 0;

  oam_dma_master u0 (.clk(clk), .rst(rst), .start(start0), .page(page0), .busy(busy0), .done(done0),
    .wen(wen0), .ren(ren0), .rdy(rdy0), .addr_out(addr0), .data_out(data0), .data_in(din0));
  oam_dma_master #(.ALIGN_CYCLES(0)) u1 (.clk(clk), .rst(rst), .start(start1), .page(page1), .busy(busy1),
    .done(done1), .wen(wen1), .ren(ren1), .rdy(rdy1), .addr_out(addr1), .data_out(data1), .data_in(din1));

  assign din0 = mem[addr0];
  assign din1 = mem[addr1];
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    rdy0 = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
  end

  always @(negedge clk) begin
    if (busy0) busy_cnt0++;
    if (done0) done_cnt0++;
    if (ren0 && wen0) both_cnt++;
    if (p_req && !p_rdy && !p_rst && !rst &&
        (ren0 !== p_ren || wen0 !== p_wen || addr0 !== p_addr || data0 !== p_data)) stab_cnt++;
    if (wen0 && rdy0) begin
      wq_a.push_back(addr0);
      wq_d.push_back(data0);
    end
    if (ren0 && rdy0) rq0.push_back(addr0);
    p_req = ren0 | wen0; p_rdy = rdy0; p_rst = rst;
    p_ren = ren0; p_wen = wen0; p_addr = addr0; p_data = data0;
    if (busy1) busy_cnt1++;
    if (done1) done_cnt1++;
    if (ren1 && rdy1) rq1.push_back(addr1);
  end

  task automatic pulse0(input logic [7:0] p);
    @(posedge clk); #1 start0 = 1; page0 = p;
    @(posedge clk); #1 start0 = 0;
  endtask

  task automatic wait_done0(input int budget);
    int k;
    for (k = 0; k < budget && !done0; k++) @(negedge clk);
    total++;
    if (!done0) begin bad++; $display("FAIL wait_done0: done=%b after %0d cycles, required 1", done0, k); end
    repeat (4) @(negedge clk);
  endtask

  task automatic fill(input logic [7:0] p, input logic [7:0] key);
    for (int i = 0; i < 256; i++) mem[{p, 8'(i)}] = 8'(i) ^ key;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    total += 6;
    if (busy0 !== 0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    if (done0 !== 0) begin bad++; $display("FAIL reset_done: got %b want 0", done0); end
    if (wen0 !== 0) begin bad++; $display("FAIL reset_wen: got %b want 0", wen0); end
    if (ren0 !== 0) begin bad++; $display("FAIL reset_ren: got %b want 0", ren0); end
    if (addr0 !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h want 0000", addr0); end
    if (data0 !== 8'h0) begin bad++; $display("FAIL reset_data: got %h want 00", data0); end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_copy(input string nm, input int wb, input int rb, input int bb, input int db,
                            input logic [7:0] p, input logic [7:0] key, input int busy_want);
    int n;
    n = wq_a.size() - wb;
    total++;
    if (n != 256) begin bad++; $display("FAIL %s_wcount: got %0d want 256", nm, n); end
    else for (int i = 0; i < 256; i++) begin
      total++;
      if (wq_a[wb+i] !== 16'h2004 || wq_d[wb+i] !== (8'(i) ^ key)) begin
        bad++; $display("FAIL %s_write%0d: got %h/%h want 2004/%h", nm, i, wq_a[wb+i], wq_d[wb+i], 8'(i) ^ key);
      end
    end
    total += 3;
    if (rq0.size() - rb != 256 || rq0[rq0.size()-1] !== {p, 8'hFF}) begin
      bad++; $display("FAIL %s_reads: got %0d ending %h want 256 ending %h", nm, rq0.size() - rb, rq0[rq0.size()-1], {p, 8'hFF});
    end
    if (busy_cnt0 - bb != busy_want) begin bad++; $display("FAIL %s_busy: got %0d want %0d", nm, busy_cnt0 - bb, busy_want); end
    if (done_cnt0 - db != 1) begin bad++; $display("FAIL %s_done: got %0d pulses want 1", nm, done_cnt0 - db); end
  endtask

  task automatic test_basic;
    int wb, rb, bb, db;
    fill(8'h02, 8'h5A);
    rdy_mode = 0;
    wb = wq_a.size(); rb = rq0.size(); bb = busy_cnt0; db = done_cnt0;
    pulse0(8'h02);
    @(negedge clk);
    total++;
    if (busy0 !== 1 || ren0 !== 0) begin bad++; $display("FAIL basic_align: busy=%b ren=%b want 1/0", busy0, ren0); end
    @(negedge clk);
    total++;
    if (ren0 !== 1 || addr0 !== 16'h0200) begin bad++; $display("FAIL basic_first_rd: ren=%b addr=%h want 1/0200", ren0, addr0); end
    wait_done0(2000);
    check_copy("basic", wb, rb, bb, db, 8'h02, 8'h5A, 513);
    total++;
    if (both_cnt != 0) begin bad++; $display("FAIL basic_both: got %0d want 0", both_cnt); end
  endtask

  task automatic test_wait_states;
    int wb, rb, bb, db;
    rdy_mode = 1;
    wb = wq_a.size(); rb = rq0.size(); bb = busy_cnt0; db = done_cnt0;
    pulse0(8'h02);
    wait_done0(3000);
    rdy_mode = 0;
    check_copy("wait", wb, rb, bb, db, 8'h02, 8'h5A, busy_cnt0 - bb);
    total += 3;
    if (busy_cnt0 - bb <= 513) begin bad++; $display("FAIL wait_stretch: busy %0d want >513", busy_cnt0 - bb); end
    if (both_cnt != 0) begin bad++; $display("FAIL wait_both: got %0d want 0", both_cnt); end
    if (stab_cnt != 0) begin bad++; $display("FAIL wait_stable: got %0d changes want 0", stab_cnt); end
  endtask

  task automatic test_restart_ignored;
    int wb, rb, bb, db, off;
    logic hit;
    fill(8'h07, 8'h11);
    wb = wq_a.size(); rb = rq0.size(); bb = busy_cnt0; db = done_cnt0;
    pulse0(8'h02);
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk); #1;
      hit = (wq_a.size() - wb >= 100);
    end
    pulse0(8'h07);
    wait_done0(2000);
    check_copy("restart", wb, rb, bb, db, 8'h02, 8'h5A, 513);
    off = 0;
    for (int i = rb; i < rq0.size(); i++) if (rq0[i][15:8] !== 8'h02) off++;
    total++;
    if (off != 0) begin bad++; $display("FAIL restart_page: got %0d off-page reads want 0", off); end
  endtask

  task automatic test_reset_mid;
    int wb, rb, bb, db;
    logic hit;
    wb = wq_a.size(); db = done_cnt0;
    pulse0(8'h02);
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk); #1;
      hit = wen0 && (wq_a.size() - wb == 41);
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rstmid_reach: wen=%b writes=%0d want byte 40 in WR", wen0, wq_a.size() - wb); end
    rst = 1;
    @(negedge clk);
    total++;
    if ({wen0, ren0, busy0, done0} !== 4'b0) begin
      bad++; $display("FAIL rstmid_outputs: wen/ren/busy/done=%b want 0000", {wen0, ren0, busy0, done0});
    end
    rst = 0;
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt0 != db) begin bad++; $display("FAIL rstmid_nodone: got %0d pulses want 0", done_cnt0 - db); end
    fill(8'h03, 8'hC3);
    wb = wq_a.size(); rb = rq0.size(); bb = busy_cnt0; db = done_cnt0;
    pulse0(8'h03);
    wait_done0(2000);
    check_copy("rstmid", wb, rb, bb, db, 8'h03, 8'hC3, 513);
  endtask

  task automatic test_align0;
    int rb, bb, db, k;
    fill(8'hFF, 8'h3C);
    rb = rq1.size(); bb = busy_cnt1; db = done_cnt1;
    @(posedge clk); #1 start1 = 1; page1 = 8'hFF;
    @(posedge clk); #1 start1 = 0;
    @(negedge clk);
    total++;
    if (ren1 !== 1 || busy1 !== 1 || addr1 !== 16'hFF00) begin
      bad++; $display("FAIL align0_first_rd: ren=%b busy=%b addr=%h want 1/1/FF00", ren1, busy1, addr1);
    end
    for (k = 0; k < 2000 && !done1; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    total += 3;
    if (done_cnt1 - db != 1) begin bad++; $display("FAIL align0_done: got %0d pulses want 1", done_cnt1 - db); end
    if (busy_cnt1 - bb != 512) begin bad++; $display("FAIL align0_busy: got %0d want 512", busy_cnt1 - bb); end
    if (rq1.size() - rb != 256 || rq1[rq1.size()-1] !== 16'hFFFF) begin
      bad++; $display("FAIL align0_last_rd: got %0d ending %h want 256 ending FFFF", rq1.size() - rb, rq1[rq1.size()-1]);
    end
  endtask

  task automatic test_start_held;
    @(posedge clk); #1 start0 = 1; page0 = 8'h02;
    wait_done_hold();
    total++;
    if (busy0 !== 0) begin bad++; $display("FAIL held_done_busy: got %b want 0", busy0); end
    @(negedge clk);
    total++;
    if (busy0 !== 0 || done0 !== 0) begin bad++; $display("FAIL held_idle: busy=%b done=%b want 0/0", busy0, done0); end
    @(negedge clk);
    total++;
    if (busy0 !== 1) begin bad++; $display("FAIL held_restart: busy=%b want 1", busy0); end
    start0 = 0;
    wait_done0(2000);
  endtask

  task automatic wait_done_hold;
    int k;
    for (k = 0; k < 2000 && !done0; k++) @(negedge clk);
    total++;
    if (!done0) begin bad++; $display("FAIL held_wait: done=%b after %0d cycles, required 1", done0, k); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wait_states;
    test_restart_ignored;
    test_reset_mid;
    test_align0;
    test_start_held;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
